gate_selftest_ctrl: RTL and testbench
=====================================

GATE_SELFTEST_CTRL -- requirements
Module: gate_selftest_ctrl

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 2, cycles the operands are held before each check; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to run the self-test; honoured only in IDLE.
REQ-005 abort  input  1  synchronous cancel of a running test.
REQ-006 a_o  output  1  operand a driven to the and/or/not gate datapath.
REQ-007 b_o  output  1  operand b driven to the gate datapath.
REQ-008 and_i  input  1  AND result returned from the datapath.
REQ-009 or_i  input  1  OR result returned from the datapath.
REQ-010 not_i  input  1  NOT(a) result returned from the datapath.
REQ-011 busy  output  1  high while a test is running.
REQ-012 done  output  1  one-cycle pulse on normal completion.
REQ-013 pass  output  1  result of the last completed test; 1 when no mismatch occurred.
REQ-014 err_count  output  4  number of mismatching gate checks in the current or last test, 0..12.
REQ-015 fail_mask  output  3  sticky per-gate mismatch flags: bit2 AND, bit1 OR, bit0 NOT.
REQ-016 first_fail_vec  output  2  vector index {a,b} of the first mismatch.
REQ-017 first_fail_valid  output  1  first_fail_vec holds a captured value.

Function
REQ-018 The FSM shall have exactly three states: IDLE, SETTLE and CHECK.
REQ-019 IDLE with start=1 and abort=0 shall, at that edge, load vector index 0, set {a_o,b_o}=00, clear err_count/fail_mask/first_fail_valid/pass, set busy=1, and enter SETTLE.
REQ-020 SETTLE shall last exactly SETTLE_CYCLES cycles (4-bit down-counter), then enter CHECK.
REQ-021 CHECK shall last one cycle and compare the inputs to expected values: and_i vs a_o&b_o, or_i vs a_o|b_o, not_i vs ~a_o.
REQ-022 Each mismatch in a CHECK shall add 1 to err_count (up to 3 per vector) and set the corresponding fail_mask bit.
REQ-023 The first CHECK with any mismatch shall capture the vector index into first_fail_vec and set first_fail_valid; later mismatches shall not overwrite it.
REQ-024 The vector order shall be 00, 01, 10, 11 (index bit1=a, bit0=b).
REQ-025 At the end of a CHECK for vector index 0..2, the block shall increment the index, update {a_o,b_o} at the same edge, and re-enter SETTLE.
REQ-026 At the end of the CHECK for index 3, the block shall enter IDLE, set busy=0, pulse done=1 for one cycle, and set pass=1 if the final err_count (including this check) is 0.
REQ-027 A normal run shall keep busy high for exactly 4*(SETTLE_CYCLES+1) cycles.
REQ-028 start while busy shall be ignored.
REQ-029 abort=1 in SETTLE or CHECK shall, at the next edge, enter IDLE with busy=0, done=0 and pass=0; err_count, fail_mask and first_fail_* shall hold their values; the check in progress shall not be scored.
REQ-030 abort and start together in IDLE: abort wins and no run starts.
REQ-031 a_o/b_o shall hold their last value in IDLE.
REQ-032 pass, err_count, fail_mask and first_fail_* shall hold from completion until the next accepted start.

Reset
REQ-033 While rst=1, regardless of clk: state=IDLE, a_o=0, b_o=0, busy=0, done=0, pass=0, err_count=0, fail_mask=000, first_fail_vec=00, first_fail_valid=0, vector index and counter 0.
REQ-034 rst asserted mid-run shall abandon the run with no done pulse; after release the block shall accept start normally.

Verification
REQ-035 Correct datapath, SETTLE_CYCLES=2, single start pulse -> busy high for 12 cycles, {a_o,b_o} sequence 00,01,10,11 each held for 3 cycles, done pulse, pass=1, err_count=0, fail_mask=000.
REQ-036 and_i stuck at 1 -> pass=0, err_count=3, fail_mask=100, first_fail_vec=00, first_fail_valid=1.
REQ-037 not_i wrongly driven as ~b -> mismatches at vectors 01 and 10; err_count=2, fail_mask=001, first_fail_vec=01.
REQ-038 abort asserted in the 2nd SETTLE of vector 10 -> next cycle busy=0, no done pulse, pass=0, counters hold; a following start gives a clean full run.
REQ-039 start re-pulsed while busy, and start+abort together in IDLE -> no restart, sequence timing unchanged / no run.
REQ-040 rst pulsed mid-CHECK at vector 01 -> all outputs at reset values immediately; SETTLE_CYCLES=1 rerun -> busy exactly 8 cycles, pass=1.

Source files
------------

// File: rtl/gate_selftest_ctrl.sv
// Self-test sequencer for a 1-bit AND/OR/NOT gate datapath.
// Latency: 4*(SETTLE_CYCLES+1) cycles from an accepted start to the done pulse.
// Backpressure: none; start is ignored while busy, abort cancels a run on the next edge.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, abort              run request (honoured in IDLE only) / synchronous cancel
//   a_o, b_o                  operands driven to the gate datapath
//   and_i, or_i, not_i        gate results returned from the datapath
//   busy, done, pass          run status; done pulses one cycle on normal completion
//   err_count, fail_mask      mismatch count and sticky per-gate flags {AND,OR,NOT}
//   first_fail_vec/_valid     {a,b} index of the first mismatching vector
module gate_selftest_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       a_o,
    output logic       b_o,
    input  logic       and_i,
    input  logic       or_i,
    input  logic       not_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] fail_mask,
    output logic [1:0] first_fail_vec,
    output logic       first_fail_valid
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK} state_t;

    // The counter is loaded with N-1 so SETTLE spans exactly N cycles.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] err_q, err_d;
    logic [2:0] mask_q, mask_d;
    logic [1:0] ffv_q, ffv_d;
    logic       ffvld_q, ffvld_d;

    logic [2:0] mis;
    logic [3:0] mis_cnt;
    logic [3:0] err_sum;

    always_comb begin
        // Operands come straight from the vector index, bit1=a, bit0=b.
        mis[2]  = and_i != (vec_q[1] & vec_q[0]);
        mis[1]  = or_i  != (vec_q[1] | vec_q[0]);
        mis[0]  = not_i != ~vec_q[1];
        mis_cnt = 4'(mis[2]) + 4'(mis[1]) + 4'(mis[0]);
        err_sum = err_q + mis_cnt;

        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        mask_d  = mask_q;
        ffv_d   = ffv_q;
        ffvld_d = ffvld_q;

        case (state_q)
            IDLE: begin
                // abort blocks a simultaneous start
                if (start && !abort) begin
                    state_d = SETTLE;
                    vec_d   = 2'd0;
                    cnt_d   = CNT_LOAD;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = 4'd0;
                    mask_d  = 3'b000;
                    ffv_d   = 2'd0;
                    ffvld_d = 1'b0;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                end else if (cnt_q == 4'd0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CHECK: begin
                if (abort) begin
                    // in-flight check is dropped, scores so far are kept
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                end else begin
                    err_d  = err_sum;
                    mask_d = mask_q | mis;
                    if ((mis != 3'b000) && !ffvld_q) begin
                        ffv_d   = vec_q;
                        ffvld_d = 1'b1;
                    end
                    if (vec_q == 2'd3) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_sum == 4'd0);
                    end else begin
                        state_d = SETTLE;
                        vec_d   = vec_q + 2'd1;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 4'd0;
            mask_q  <= 3'b000;
            ffv_q   <= 2'd0;
            ffvld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            ffv_q   <= ffv_d;
            ffvld_q <= ffvld_d;
        end
    end

    assign a_o              = vec_q[1];
    assign b_o              = vec_q[0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign fail_mask        = mask_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvld_q;

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Bench for gate_selftest_ctrl: fault-injecting gate datapath, scoreboard of expected run results.
// Two instances: SETTLE_CYCLES=2 (main, randomized) and SETTLE_CYCLES=1 (rerun after reset).
module tb_gate_selftest_ctrl;

    localparam int S  = 2;
    localparam int S1 = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic       a_o, b_o, and_i, or_i, not_i;
    logic       busy, done, pass, ffvld;
    logic [3:0] err_count;
    logic [2:0] fail_mask;
    logic [1:0] ffvec;

    logic       start1 = 1'b0;
    logic       a1, b1, busy1, done1, pass1, ffvld1;
    logic [3:0] err1;
    logic [2:0] mask1;
    logic [1:0] ffvec1;

    // 0 good, 1 AND stuck at 1, 2 NOT driven as ~b, 3 random per-vector flips
    int         fault_mode = 0;
    logic [2:0] flip_tbl [4];

    int checks = 0;
    int failures = 0;

    typedef struct {
        int err; int mask; int ffvec; int ffvalid; int pass; int blen; int aborted;
    } exp_t;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    gate_selftest_ctrl #(.SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a_o(a_o), .b_o(b_o), .and_i(and_i), .or_i(or_i), .not_i(not_i),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_mask(fail_mask), .first_fail_vec(ffvec), .first_fail_valid(ffvld)
    );

    gate_selftest_ctrl #(.SETTLE_CYCLES(S1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0),
        .a_o(a1), .b_o(b1), .and_i(a1 & b1), .or_i(a1 | b1), .not_i(~a1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_mask(mask1), .first_fail_vec(ffvec1), .first_fail_valid(ffvld1)
    );

    // Faulty gate datapath
    always_comb begin
        and_i = a_o & b_o;
        or_i  = a_o | b_o;
        not_i = ~a_o;
        case (fault_mode)
            1: and_i = 1'b1;
            2: not_i = ~b_o;
            3: {and_i, or_i, not_i} = {a_o & b_o, a_o | b_o, ~a_o} ^ flip_tbl[{a_o, b_o}];
            default: ;
        endcase
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: walk the four vectors, score those that finished their CHECK before any abort.
    function automatic exp_t model(input int mode, input int abort_k);
        exp_t e;
        int nscored;
        e.err = 0; e.mask = 0; e.ffvec = 0; e.ffvalid = 0;
        nscored = (abort_k < 0) ? 4 : abort_k / (S + 1);
        for (int v = 0; v < nscored; v++) begin
            int a, b, want_and, want_or, want_not, got_and, got_or, got_not, m;
            a = v / 2; b = v % 2;
            want_and = a & b; want_or = a | b; want_not = 1 - a;
            got_and = want_and; got_or = want_or; got_not = want_not;
            if (mode == 1) got_and = 1;
            if (mode == 2) got_not = 1 - b;
            if (mode == 3) begin
                got_and = got_and ^ int'(flip_tbl[v][2]);
                got_or  = got_or  ^ int'(flip_tbl[v][1]);
                got_not = got_not ^ int'(flip_tbl[v][0]);
            end
            m = 0;
            if (got_and != want_and) begin e.err++; m |= 4; end
            if (got_or  != want_or)  begin e.err++; m |= 2; end
            if (got_not != want_not) begin e.err++; m |= 1; end
            e.mask |= m;
            if (m != 0 && e.ffvalid == 0) begin e.ffvec = v; e.ffvalid = 1; end
        end
        e.aborted = (abort_k >= 0);
        e.pass    = (!e.aborted && e.err == 0);
        e.blen    = e.aborted ? abort_k + 1 : 4 * (S + 1);
        return e;
    endfunction

    // Monitor: checks the operand sequence during a run and the result when busy drops.
    initial begin
        bit busy_prev = 1'b0;
        int bcnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                busy_prev = 1'b0;
                bcnt = 0;
            end else begin
                if (busy) begin
                    if (!busy_prev) chk("run_expected", exp_q.size(), 1);
                    chk("operands", int'({a_o, b_o}), bcnt / (S + 1));
                    bcnt++;
                end else if (busy_prev) begin
                    if (exp_q.size() == 0) begin
                        chk("result_queued", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("busy_len",  bcnt, e.blen);
                        chk("done",      int'(done), e.aborted ? 0 : 1);
                        chk("pass",      int'(pass), e.pass);
                        chk("err_count", int'(err_count), e.err);
                        chk("fail_mask", int'(fail_mask), e.mask);
                        chk("ff_valid",  int'(ffvld), e.ffvalid);
                        if (e.ffvalid != 0) chk("ff_vec", int'(ffvec), e.ffvec);
                    end
                    bcnt = 0;
                end else begin
                    chk("no_stray_done", int'(done), 0);
                end
                busy_prev = busy;
            end
        end
    end

    // One run starting at posedge+1; abort_k<0 means run to completion.
    task automatic do_run(input int mode, input int abort_k, input bit repulse);
        int total;
        fault_mode = mode;
        exp_q.push_back(model(mode, abort_k));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total = (abort_k >= 0) ? abort_k : 4 * (S + 1);
        for (int j = 0; j < total; j++) begin
            start = (repulse && j == 3) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (abort_k >= 0) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ab"},    int'({a_o, b_o}), 0);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_done"},  int'(done), 0);
        chk({tag, "_pass"},  int'(pass), 0);
        chk({tag, "_err"},   int'(err_count), 0);
        chk({tag, "_mask"},  int'(fail_mask), 0);
        chk({tag, "_ffvec"}, int'(ffvec), 0);
        chk({tag, "_ffvld"}, int'(ffvld), 0);
    endtask

    initial begin
        int cnt1;
        bit seen_done1;
        for (int v = 0; v < 4; v++) flip_tbl[v] = 3'b000;

        #2 rst = 1'b1;
        #1 chk_reset_vals("reset");
        @(negedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_run(0, -1, 1'b0);          // clean run
        do_run(1, -1, 1'b0);          // AND stuck at 1
        do_run(2, -1, 1'b0);          // NOT driven as ~b
        do_run(0, 2 * (S + 1) + 1, 1'b0);  // abort in 2nd SETTLE of vector 10
        do_run(0, -1, 1'b0);          // clean run after abort
        do_run(0, -1, 1'b1);          // start re-pulsed while busy

        // start and abort together in IDLE: no run
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        chk("start_abort_idle_busy", int'(busy), 0);
        repeat (2) begin @(posedge clk); #1; end

        // reset asserted during the CHECK of vector 01
        exp_q.push_back(model(0, -1));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2 * (S + 1) - 1) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1 chk_reset_vals("midrun_reset");
        @(negedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // short-settle instance: full run right after reset release
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cnt1 = 0; seen_done1 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy1) cnt1++;
            if (done1) seen_done1 = 1'b1;
        end
        chk("s1_busy_len", cnt1, 4 * (S1 + 1));
        chk("s1_done",     int'(seen_done1), 1);
        chk("s1_pass",     int'(pass1), 1);
        chk("s1_err",      int'(err1), 0);
        @(posedge clk); #1;

        do_run(0, -1, 1'b0);          // main instance accepts start after reset

        for (int r = 0; r < 25; r++) begin
            int mode, ak;
            mode = $urandom_range(0, 3);
            for (int v = 0; v < 4; v++) flip_tbl[v] = 3'($urandom_range(0, 7));
            ak = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4 * (S + 1) - 1) : -1;
            do_run(mode, ak, 1'($urandom_range(0, 1)));
        end

        @(posedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
